protected_region_table: RTL and testbench

- Parametrised successor to the single write-once protected flag: holds NUM_REGIONS address ranges, each armed once after reset and then immutable until the next reset.
- Every bus access is checked against all armed regions; hits are reported one cycle later, and violations are captured in a sticky flag, a first-fault address and a saturating count.
- Sits beside the bus decoder/arbiter.
- Feeds an access-abort and an interrupt source.

---
 rtl/protected_region_table_pkg.sv | 24 ++
 rtl/protected_region_cmp.sv | 18 +
 rtl/protected_region_table.sv | 155 +++++++++++++++
 tb/tb_protected_region_table.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/protected_region_table_pkg.sv
// Shared types and constants for the protected region table.
// Latency: n/a (types only).
// Backpressure: n/a.
// Region records are stored at a fixed maximum address width; narrower
// buses zero-extend into them and the unused upper bits stay constant 0.
package protected_region_table_pkg;

   // Widest supported bus address; BUS_WIDTH of the table must not exceed it.
   localparam int unsigned PRT_AW = 64;

   // One protected address range. base/limit are inclusive and unsigned.
   typedef struct packed {
      logic [PRT_AW-1:0] base;
      logic [PRT_AW-1:0] limit;
      logic              ro;
      logic              valid;
   } region_t;

   localparam region_t REGION_RESET = '0;

   // Source of the counter saturation value; sliced to CNT_WIDTH by the user.
   localparam logic [63:0] CNT_ALL_ONES = '1;

endpackage

// File: rtl/protected_region_cmp.sv
// Per-slot range comparator: flags an address inside an armed region.
// Latency: purely combinational.
// Backpressure: none.
// Ports: region_i (slot record), addr_i (zero-extended access address),
//        hit_o (slot armed and base <= addr <= limit, inclusive).
module protected_region_cmp
   import protected_region_table_pkg::*;
(
   input  region_t           region_i,
   input  logic [PRT_AW-1:0] addr_i,
   output logic              hit_o
);

   assign hit_o = region_i.valid
                & (addr_i >= region_i.base)
                & (addr_i <= region_i.limit);

endmodule

// File: rtl/protected_region_table.sv
// Write-once table of protected address ranges with access checking and violation capture.
// Latency: chk_* and viol_* reflect an access one cycle after it is presented.
// Backpressure: none; every access and arm request is evaluated in its own cycle.
// Ports: clk/nreset; cfg_* arm request (cfg_err pulses on reject, region_valid is the armed
//        bitmap); chk_* access in, registered hit/region/deny out; viol_* sticky capture + clear.
module protected_region_table
   import protected_region_table_pkg::*;
#(
   parameter int unsigned BUS_WIDTH   = 32,
   parameter int unsigned NUM_REGIONS = 4,
   parameter int unsigned IDX_WIDTH   = 2,
   parameter int unsigned CNT_WIDTH   = 8
)(
   input  logic                   clk,
   input  logic                   nreset,
   input  logic                   cfg_set,
   input  logic [IDX_WIDTH-1:0]   cfg_idx,
   input  logic [BUS_WIDTH-1:0]   cfg_base,
   input  logic [BUS_WIDTH-1:0]   cfg_limit,
   input  logic                   cfg_ro,
   input  logic                   cfg_lock_all,
   output logic                   cfg_err,
   output logic [NUM_REGIONS-1:0] region_valid,
   input  logic                   chk_valid,
   input  logic [BUS_WIDTH-1:0]   chk_addr,
   input  logic                   chk_write,
   output logic                   chk_hit,
   output logic [IDX_WIDTH-1:0]   chk_region,
   output logic                   chk_deny,
   output logic                   viol_flag,
   output logic [BUS_WIDTH-1:0]   viol_addr,
   output logic [CNT_WIDTH-1:0]   viol_count,
   input  logic                   viol_clr
);

   localparam logic [CNT_WIDTH-1:0] CNT_SAT = CNT_ALL_ONES[CNT_WIDTH-1:0];

   region_t                regions_q [NUM_REGIONS];
   region_t                regions_d [NUM_REGIONS];
   logic                   cfg_err_q, cfg_err_d;
   logic                   chk_hit_q, chk_hit_d;
   logic [IDX_WIDTH-1:0]   chk_region_q, chk_region_d;
   logic                   chk_deny_q, chk_deny_d;
   logic                   viol_flag_q, viol_flag_d;
   logic [BUS_WIDTH-1:0]   viol_addr_q, viol_addr_d;
   logic [CNT_WIDTH-1:0]   viol_count_q, viol_count_d;

   logic [NUM_REGIONS-1:0] hit_vec;
   logic [PRT_AW-1:0]      addr_ext;
   logic                   slot_busy, idx_ok, arm_ok;
   logic                   hit_any, sel_ro;
   logic [IDX_WIDTH-1:0]   sel_idx;

   assign addr_ext = PRT_AW'(chk_addr);

   // Comparators see the pre-edge region state, so an arm in the same
   // cycle as an access never protects that access.
   for (genvar g = 0; g < NUM_REGIONS; g++) begin : g_slot
      protected_region_cmp u_cmp (
         .region_i (regions_q[g]),
         .addr_i   (addr_ext),
         .hit_o    (hit_vec[g])
      );
      assign region_valid[g] = regions_q[g].valid;
   end

   // Arm logic: write-once slots, rejected on lock, bad index or inverted bounds.
   always_comb begin
      slot_busy = 1'b0;
      for (int i = 0; i < NUM_REGIONS; i++) begin
         if (cfg_idx == IDX_WIDTH'(i)) slot_busy = regions_q[i].valid;
      end
      idx_ok    = (32'(cfg_idx) < NUM_REGIONS);
      arm_ok    = cfg_set & ~cfg_lock_all & idx_ok & ~slot_busy & (cfg_base <= cfg_limit);
      cfg_err_d = cfg_set & ~arm_ok;
      for (int i = 0; i < NUM_REGIONS; i++) begin
         regions_d[i] = regions_q[i];
         if (arm_ok && (cfg_idx == IDX_WIDTH'(i))) begin
            regions_d[i].base  = PRT_AW'(cfg_base);
            regions_d[i].limit = PRT_AW'(cfg_limit);
            regions_d[i].ro    = cfg_ro;
            regions_d[i].valid = 1'b1;
         end
      end
   end

   // Priority encoder: scanning downward leaves the lowest hit index selected,
   // which also decides the ro attribute when regions overlap.
   always_comb begin
      hit_any = 1'b0;
      sel_idx = '0;
      sel_ro  = 1'b0;
      for (int i = NUM_REGIONS - 1; i >= 0; i--) begin
         if (hit_vec[i]) begin
            hit_any = 1'b1;
            sel_idx = IDX_WIDTH'(i);
            sel_ro  = regions_q[i].ro;
         end
      end
      chk_hit_d    = chk_valid & hit_any;
      chk_region_d = chk_hit_d ? sel_idx : '0;
      chk_deny_d   = chk_hit_d & (chk_write | ~sel_ro);
   end

   // Violation capture: a clear is applied before a same-cycle deny, so that
   // deny becomes the new first fault.
   always_comb begin
      viol_flag_d  = viol_flag_q;
      viol_addr_d  = viol_addr_q;
      viol_count_d = viol_count_q;
      if (viol_clr) begin
         viol_flag_d  = 1'b0;
         viol_addr_d  = '0;
         viol_count_d = '0;
      end
      if (chk_deny_d) begin
         if (!viol_flag_d) begin
            viol_flag_d = 1'b1;
            viol_addr_d = chk_addr;
         end
         if (viol_count_d != CNT_SAT) viol_count_d = viol_count_d + CNT_WIDTH'(1);
      end
   end

   always_ff @(posedge clk or negedge nreset) begin
      if (!nreset) begin
         for (int i = 0; i < NUM_REGIONS; i++) regions_q[i] <= REGION_RESET;
         cfg_err_q    <= 1'b0;
         chk_hit_q    <= 1'b0;
         chk_region_q <= '0;
         chk_deny_q   <= 1'b0;
         viol_flag_q  <= 1'b0;
         viol_addr_q  <= '0;
         viol_count_q <= '0;
      end else begin
         for (int i = 0; i < NUM_REGIONS; i++) regions_q[i] <= regions_d[i];
         cfg_err_q    <= cfg_err_d;
         chk_hit_q    <= chk_hit_d;
         chk_region_q <= chk_region_d;
         chk_deny_q   <= chk_deny_d;
         viol_flag_q  <= viol_flag_d;
         viol_addr_q  <= viol_addr_d;
         viol_count_q <= viol_count_d;
      end
   end

   assign cfg_err    = cfg_err_q;
   assign chk_hit    = chk_hit_q;
   assign chk_region = chk_region_q;
   assign chk_deny   = chk_deny_q;
   assign viol_flag  = viol_flag_q;
   assign viol_addr  = viol_addr_q;
   assign viol_count = viol_count_q;

endmodule

// File: tb/tb_protected_region_table.sv
// Bench for protected_region_table: directed scenarios plus randomized traffic
// checked against a table-level reference model of regions and violations.
module tb_protected_region_table;

   localparam int NR = 4;

   logic        clk = 1'b0;
   logic        nreset;
   logic        cfg_set;
   logic [1:0]  cfg_idx;
   logic [31:0] cfg_base, cfg_limit;
   logic        cfg_ro, cfg_lock_all;
   logic        cfg_err;
   logic [3:0]  region_valid;
   logic        chk_valid;
   logic [31:0] chk_addr;
   logic        chk_write;
   logic        chk_hit;
   logic [1:0]  chk_region;
   logic        chk_deny;
   logic        viol_flag;
   logic [31:0] viol_addr;
   logic [7:0]  viol_count;
   logic        viol_clr;

   always #5 clk = ~clk;

   protected_region_table #(
      .BUS_WIDTH   (32),
      .NUM_REGIONS (NR),
      .IDX_WIDTH   (2),
      .CNT_WIDTH   (8)
   ) dut (
      .clk          (clk),
      .nreset       (nreset),
      .cfg_set      (cfg_set),
      .cfg_idx      (cfg_idx),
      .cfg_base     (cfg_base),
      .cfg_limit    (cfg_limit),
      .cfg_ro       (cfg_ro),
      .cfg_lock_all (cfg_lock_all),
      .cfg_err      (cfg_err),
      .region_valid (region_valid),
      .chk_valid    (chk_valid),
      .chk_addr     (chk_addr),
      .chk_write    (chk_write),
      .chk_hit      (chk_hit),
      .chk_region   (chk_region),
      .chk_deny     (chk_deny),
      .viol_flag    (viol_flag),
      .viol_addr    (viol_addr),
      .viol_count   (viol_count),
      .viol_clr     (viol_clr)
   );

   int passes = 0;
   int total  = 0;
   int fails  = 0;

   // Reference model state
   logic [31:0] m_base  [NR];
   logic [31:0] m_limit [NR];
   logic        m_ro    [NR];
   logic        m_valid [NR];
   logic        m_flag;
   logic [31:0] m_addr;
   int          m_cnt;
   logic        e_err, e_hit, e_deny;
   logic [1:0]  e_reg;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passes++;
      else begin
         fails++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < NR; i++) begin
         m_base[i] = '0; m_limit[i] = '0; m_ro[i] = 1'b0; m_valid[i] = 1'b0;
      end
      m_flag = 1'b0; m_addr = '0; m_cnt = 0;
   endtask

   function automatic logic [3:0] m_valid_bits();
      logic [3:0] v;
      for (int i = 0; i < NR; i++) v[i] = m_valid[i];
      return v;
   endfunction

   task automatic idle_inputs();
      cfg_set = 0; cfg_idx = 0; cfg_base = 0; cfg_limit = 0; cfg_ro = 0; cfg_lock_all = 0;
      chk_valid = 0; chk_addr = 0; chk_write = 0; viol_clr = 0;
   endtask

   // One clock: predict from current inputs and pre-edge model, then compare all outputs.
   task automatic step();
      int hi;
      hi = -1;
      if (chk_valid)
         for (int i = 0; i < NR; i++)
            if (hi < 0 && m_valid[i] && chk_addr >= m_base[i] && chk_addr <= m_limit[i]) hi = i;
      e_hit  = (hi >= 0);
      e_reg  = e_hit ? 2'(hi) : 2'd0;
      e_deny = e_hit && (chk_write || !m_ro[e_hit ? hi : 0]);
      e_err  = cfg_set && (cfg_lock_all || int'(cfg_idx) >= NR || m_valid[cfg_idx]
                           || cfg_base > cfg_limit);
      @(posedge clk);
      #1;
      if (viol_clr) begin
         m_flag = 1'b0; m_addr = '0; m_cnt = 0;
      end
      if (e_deny) begin
         if (!m_flag) begin m_flag = 1'b1; m_addr = chk_addr; end
         if (m_cnt < 255) m_cnt++;
      end
      if (cfg_set && !e_err) begin
         m_base[cfg_idx] = cfg_base; m_limit[cfg_idx] = cfg_limit;
         m_ro[cfg_idx] = cfg_ro; m_valid[cfg_idx] = 1'b1;
      end
      check("cfg_err",      cfg_err,      e_err);
      check("region_valid", region_valid, m_valid_bits());
      check("chk_hit",      chk_hit,      e_hit);
      check("chk_region",   chk_region,   e_reg);
      check("chk_deny",     chk_deny,     e_deny);
      check("viol_flag",    viol_flag,    m_flag);
      check("viol_addr",    viol_addr,    m_addr);
      check("viol_count",   viol_count,   32'(m_cnt));
   endtask

   task automatic arm(input logic [1:0] idx, input logic [31:0] b, input logic [31:0] l,
                      input logic ro);
      cfg_set = 1; cfg_idx = idx; cfg_base = b; cfg_limit = l; cfg_ro = ro;
      step();
      cfg_set = 0;
   endtask

   task automatic acc(input logic [31:0] a, input logic wr);
      chk_valid = 1; chk_addr = a; chk_write = wr;
      step();
      chk_valid = 0;
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_cfg_err"},    cfg_err,      0);
      check({tag, "_valid"},      region_valid, 0);
      check({tag, "_chk_hit"},    chk_hit,      0);
      check({tag, "_chk_region"}, chk_region,   0);
      check({tag, "_chk_deny"},   chk_deny,     0);
      check({tag, "_viol_flag"},  viol_flag,    0);
      check({tag, "_viol_addr"},  viol_addr,    0);
      check({tag, "_viol_count"}, viol_count,   0);
   endtask

   initial begin
      idle_inputs();
      nreset = 0;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      check_all_zero("rst");
      nreset = 1;

      // Basic arm, read inside, write at inclusive limit.
      arm(2'd0, 32'h100, 32'h1FF, 1'b1);
      check("arm0_valid", region_valid, 4'b0001);
      check("arm0_err", cfg_err, 0);
      acc(32'h150, 0);
      check("rd150_hit", chk_hit, 1);
      check("rd150_deny", chk_deny, 0);
      acc(32'h1FF, 1);
      check("wr1ff_deny", chk_deny, 1);
      check("wr1ff_vaddr", viol_addr, 32'h1FF);
      check("wr1ff_vcnt", viol_count, 1);

      // Write-once and inverted bounds are rejected for exactly one cycle.
      arm(2'd0, 32'h200, 32'h2FF, 1'b0);
      check("rearm_err", cfg_err, 1);
      step();
      check("rearm_err_drop", cfg_err, 0);
      arm(2'd1, 32'h300, 32'h2FF, 1'b0);
      check("badbnd_err", cfg_err, 1);
      check("badbnd_valid", region_valid, 4'b0001);
      acc(32'h250, 0);
      check("idx0_unchanged", chk_hit, 0);

      // Lock rejects, then retry succeeds.
      cfg_lock_all = 1;
      arm(2'd2, 32'h800, 32'h8FF, 1'b0);
      check("lock_err", cfg_err, 1);
      cfg_lock_all = 0;
      arm(2'd2, 32'h800, 32'h8FF, 1'b0);
      check("unlock_valid", region_valid, 4'b0101);

      // Overlap: lowest index decides ro.
      arm(2'd1, 32'h000, 32'hFFF, 1'b1);
      acc(32'h880, 0);
      check("ovl_region", chk_region, 1);
      check("ovl_deny", chk_deny, 0);

      // First-fault address and count.
      viol_clr = 1; step(); viol_clr = 0;
      check("clr_count", viol_count, 0);
      acc(32'h120, 1);
      acc(32'h130, 1);
      check("ff_addr", viol_addr, 32'h120);
      check("ff_count", viol_count, 2);
      viol_clr = 1; acc(32'h140, 1); viol_clr = 0;
      check("clrdeny_flag", viol_flag, 1);
      check("clrdeny_addr", viol_addr, 32'h140);
      check("clrdeny_count", viol_count, 1);

      // Saturation.
      for (int n = 0; n < 300; n++) acc($urandom_range(32'h100, 32'h1FF), 1'b1);
      check("sat_count", viol_count, 255);

      // Same-cycle arm does not protect the access; single-address region.
      cfg_set = 1; cfg_idx = 2'd3; cfg_base = 32'h2000; cfg_limit = 32'h2000; cfg_ro = 0;
      chk_valid = 1; chk_addr = 32'h2000; chk_write = 0;
      step();
      cfg_set = 0; chk_valid = 0;
      check("samecyc_hit", chk_hit, 0);
      acc(32'h2000, 0);
      check("single_region", chk_region, 3);
      check("single_deny", chk_deny, 1);

      // Reset with an access in flight.
      chk_valid = 1; chk_addr = 32'h2000; chk_write = 1;
      #2 nreset = 0;
      #1;
      check_all_zero("midrst");
      model_reset();
      @(posedge clk);
      #1;
      idle_inputs();
      nreset = 1;
      step();
      check("postrst_hit", chk_hit, 0);
      check("postrst_valid", region_valid, 0);

      // Top of address space.
      arm(2'd0, 32'hFFFF_FFF0, 32'hFFFF_FFFF, 1'b1);
      acc(32'hFFFF_FFFF, 1);
      check("top_deny", chk_deny, 1);

      // Randomized traffic against the model.
      for (int n = 0; n < 500; n++) begin
         cfg_set      = ($urandom_range(0, 7) == 0);
         cfg_idx      = 2'($urandom_range(0, 3));
         cfg_base     = $urandom_range(0, 32'h1000);
         cfg_limit    = ($urandom_range(0, 7) == 0) ? cfg_base - 1 :
                        cfg_base + $urandom_range(0, 32'h400);
         cfg_ro       = 1'($urandom_range(0, 1));
         cfg_lock_all = ($urandom_range(0, 9) == 0);
         chk_valid    = ($urandom_range(0, 3) != 0);
         chk_addr     = ($urandom_range(0, 15) == 0) ? 32'hFFFF_FFF0 + $urandom_range(0, 15) :
                        $urandom_range(0, 32'h1500);
         chk_write    = 1'($urandom_range(0, 1));
         viol_clr     = ($urandom_range(0, 15) == 0);
         step();
      end
      idle_inputs();

      $display("%0d/%0d checks passed", passes, total);
      $finish;
   end

endmodule
